// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular FIFO.
// Bytes are queued on WR and sent LSB-first with one start and one stop bit.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 2613,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DBIT         = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WR,
  input  logic [DBIT-1:0] DIN,
  output logic            FULL,
  output logic            EMPTY,
  output logic            TX,
  output logic            TX_BUSY,
  output logic            TX_DONE
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DBIT - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DBIT-1:0]   shift, shift_n;
  logic              pop;
  logic              tx_n, busy_n, done_n;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count, count_n;
  logic              push;

  // A write is taken only when the pre-edge FULL flag is clear
  assign push = WR && !FULL;

  // Occupancy after this edge: simultaneous push and pop cancel out
  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + 1'b1;
    end else if (!push && pop) begin
      count_n = count - 1'b1;
    end
  end

  // FIFO pointers, count and registered status flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      FULL  <= 1'b0;
      EMPTY <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_n;
      FULL  <= (count_n == COUNT_MAX);
      EMPTY <= (count_n == '0);
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= DIN;
  end

  // State register plus registered line outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      TX      <= 1'b1;
      TX_BUSY <= 1'b0;
      TX_DONE <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      TX      <= tx_n;
      TX_BUSY <= busy_n;
      TX_DONE <= done_n;
    end
  end

  // Next-state: bit timing, bit index and shift register
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          cnt_n   = '0;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flops line up with it
  always_comb begin
    tx_n   = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      DATA: begin
        tx_n   = shift_n[0];
        busy_n = 1'b1;
      end
      STOP: begin
        busy_n = 1'b1;
        done_n = (cnt_n == CNT_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-position model checked every cycle,
// a line monitor that decodes frames, and directed literal checks.
`timescale 1ns/100ps
module tb_uart_tx_fifo;

  localparam int FAST_CPB = 4;
  localparam int SLOW_CPB = 2613;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 10 * FAST_CPB;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       WR    = 1'b0;
  logic [7:0] DIN   = 8'h00;
  logic       FULL, EMPTY, TX, TX_BUSY, TX_DONE;

  logic       wr_s  = 1'b0;
  logic [7:0] din_s = 8'h00;
  logic       full_s, empty_s, tx_s, busy_s, done_s;

  int checks = 0;
  int errors = 0;

  always #1 CLK = ~CLK;

  uart_tx_fifo #(.CLKS_PER_BIT(FAST_CPB), .ADDR_W(2), .DBIT(8)) dut (
    .CLK(CLK), .RESET(RESET), .WR(WR), .DIN(DIN), .FULL(FULL), .EMPTY(EMPTY),
    .TX(TX), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(SLOW_CPB), .ADDR_W(2), .DBIT(8)) dut_slow (
    .CLK(CLK), .RESET(RESET), .WR(wr_s), .DIN(din_s), .FULL(full_s), .EMPTY(empty_s),
    .TX(tx_s), .TX_BUSY(busy_s), .TX_DONE(done_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a position inside the current frame
  logic [7:0] mq[$];
  bit         m_act  = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_pop, m_wr;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[3'(k - 1)];
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      m_pop = !m_act && (mq.size() != 0);
      m_wr  = WR && (mq.size() < DEPTH);
      if (m_act) begin
        if (m_t == FRAME - 1) m_act = 1'b0;
        else m_t++;
      end else if (m_pop) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_t    = 0;
      end
      if (m_wr) mq.push_back(DIN);
    end
  end

  // Every-cycle comparison of the fast DUT against the model
  always @(negedge CLK) begin
    check("model_tx",    32'(TX),      32'(m_act ? frame_bit(m_byte, m_t / FAST_CPB) : 1'b1));
    check("model_busy",  32'(TX_BUSY), 32'(m_act));
    check("model_done",  32'(TX_DONE), 32'(m_act && (m_t == FRAME - 1)));
    check("model_full",  32'(FULL),    32'(mq.size() == DEPTH));
    check("model_empty", 32'(EMPTY),   32'(mq.size() == 0));
  end

  // Line monitor: decodes frames on the fast TX and records idle gaps
  logic [9:0] frames[$];
  int         gaps[$];
  bit         min_frame = 1'b0;
  int         mpos = 0;
  int         midle = 0;
  logic [9:0] mbits = '0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         done_pos = -1;

  always @(negedge CLK) begin
    if (RESET) begin
      min_frame = 1'b0;
      midle     = 0;
    end else begin
      if (!min_frame) begin
        if (TX == 1'b0) begin
          min_frame = 1'b1;
          mpos      = 0;
          gaps.push_back(midle);
        end else begin
          midle++;
        end
      end else begin
        mpos++;
      end
      if (TX_BUSY) busy_cnt++;
      if (TX_DONE) begin
        done_cnt++;
        done_pos = mpos;
      end
      if (min_frame) begin
        if (mpos % FAST_CPB == FAST_CPB / 2) mbits[4'(mpos / FAST_CPB)] = TX;
        if (mpos == FRAME - 1) begin
          min_frame = 1'b0;
          midle     = 0;
          frames.push_back(mbits);
        end
      end
    end
  end

  task automatic wait_frames(input int n, input int budget, input string name);
    int waited;
    waited = 0;
    while (frames.size() < n && waited < budget) begin
      @(negedge CLK);
      waited++;
    end
    check(name, 32'(frames.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    int         bad;
    logic       b0, b1;
    logic [9:0] exp_s;
    logic [9:0] rx;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_busy", 32'(TX_BUSY), 32'd0);
    check("rst_done", 32'(TX_DONE), 32'd0);
    RESET = 1'b0;

    // Single byte 0x32: latency, bit pattern, busy length, done position
    frames.delete(); gaps.delete();
    busy_cnt = 0; done_cnt = 0; done_pos = -1;
    @(negedge CLK); WR = 1'b1; DIN = 8'h32;
    @(negedge CLK); WR = 1'b0; DIN = 8'hFF;
    check("t1_empty_after_wr", 32'(EMPTY), 32'd0);
    check("t1_tx_idle_after_wr", 32'(TX), 32'd1);
    @(negedge CLK);
    check("t1_tx_low_2_edges", 32'(TX), 32'd0);
    wait_frames(1, 100, "t1_frame_seen");
    repeat (3) @(negedge CLK);
    if (frames.size() >= 1) check("t1_bits", 32'(frames[0]), 32'(10'b1001100100));
    check("t1_busy_cycles", 32'(busy_cnt), 32'd40);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_done_pos", 32'(done_pos), 32'd39);
    check("t1_busy_low_after", 32'(TX_BUSY), 32'd0);

    // Back-to-back 0x2B, 0x35; second write lands on the pop edge
    frames.delete(); gaps.delete();
    @(negedge CLK); WR = 1'b1; DIN = 8'h2B;
    @(negedge CLK); DIN = 8'h35;
    @(negedge CLK); WR = 1'b0;
    check("t6_empty_wr_pop", 32'(EMPTY), 32'd0);
    check("t6_full_wr_pop", 32'(FULL), 32'd0);
    wait_frames(2, 200, "t2_frames_seen");
    repeat (2) @(negedge CLK);
    if (frames.size() >= 2) begin
      check("t2_bits_first", 32'(frames[0]), 32'(10'b1001010110));
      check("t2_bits_second", 32'(frames[1]), 32'(10'b1001101010));
    end
    if (gaps.size() >= 2) check("t2_idle_gap", 32'(gaps[1]), 32'd1);
    check("t2_empty_end", 32'(EMPTY), 32'd1);

    // Overflow: 0x01..0x06 on consecutive cycles, 0x06 dropped
    frames.delete(); gaps.delete();
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK); WR = 1'b1; DIN = 8'(i);
      if (i == 5) check("t3_not_full_at_3", 32'(FULL), 32'd0);
      if (i == 6) check("t3_full_after_4", 32'(FULL), 32'd1);
    end
    @(negedge CLK); WR = 1'b0;
    check("t3_full_hold", 32'(FULL), 32'd1);
    wait_frames(5, 400, "t3_frames_seen");
    repeat (60) @(negedge CLK);
    check("t3_frame_count", 32'(frames.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (frames.size() > i) check("t3_byte", 32'(frames[i][8:1]), 32'(i + 1));
    end
    check("t3_empty_end", 32'(EMPTY), 32'd1);

    // Full FIFO and pop on the same edge: write is dropped
    frames.delete(); gaps.delete();
    @(negedge CLK); WR = 1'b1; DIN = 8'h11;
    @(negedge CLK); DIN = 8'h22;
    @(negedge CLK); DIN = 8'h33;
    @(negedge CLK); DIN = 8'h44;
    @(negedge CLK); DIN = 8'h55;
    @(negedge CLK); WR = 1'b0;
    check("t7_full", 32'(FULL), 32'd1);
    w = 0;
    while (!TX_DONE && w < 200) begin
      @(negedge CLK);
      w++;
    end
    check("t7_done_seen", 32'(TX_DONE), 32'd1);
    @(negedge CLK);
    check("t7_idle_full", 32'(FULL), 32'd1);
    check("t7_idle_tx", 32'(TX), 32'd1);
    WR = 1'b1; DIN = 8'hEE;
    @(negedge CLK); WR = 1'b0;
    check("t7_write_dropped", 32'(FULL), 32'd0);
    check("t7_popped", 32'(TX), 32'd0);
    wait_frames(5, 400, "t7_frames_seen");
    repeat (60) @(negedge CLK);
    check("t7_frame_count", 32'(frames.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (frames.size() > i) check("t7_byte", 32'(frames[i][8:1]), 32'(8'h11 * (i + 1)));
    end

    // Asynchronous reset during DATA bit 3 of 0x55 with two bytes queued
    frames.delete(); gaps.delete();
    @(negedge CLK); WR = 1'b1; DIN = 8'h55;
    @(negedge CLK); DIN = 8'hA1;
    @(negedge CLK); DIN = 8'hB2;
    @(negedge CLK); WR = 1'b0;
    repeat (16) @(negedge CLK);
    check("t4_in_frame", 32'(TX_BUSY), 32'd1);
    check("t4_bit3_low", 32'(TX), 32'd0);
    check("t4_queued", 32'(EMPTY), 32'd0);
    #0.4 RESET = 1'b1;
    #0.2;
    check("t4_async_tx", 32'(TX), 32'd1);
    check("t4_async_busy", 32'(TX_BUSY), 32'd0);
    check("t4_async_empty", 32'(EMPTY), 32'd1);
    check("t4_async_full", 32'(FULL), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (TX !== 1'b1) bad++;
    end
    check("t4_idle_100", 32'(bad), 32'd0);
    check("t4_no_frames", 32'(frames.size()), 32'd0);
    check("t4_empty_after", 32'(EMPTY), 32'd1);

    // Default bit period: 0x0D at 2613 clocks per bit, 2 ns clock
    exp_s = 10'b1000011010;
    @(negedge CLK); wr_s = 1'b1; din_s = 8'h0D;
    @(negedge CLK); wr_s = 1'b0;
    check("t5_empty_after_wr", 32'(empty_s), 32'd0);
    w = 0;
    while (tx_s !== 1'b0 && w < 10) begin
      @(negedge CLK);
      w++;
    end
    check("t5_start_seen", 32'(tx_s), 32'd0);
    check("t5_latency", 32'(w), 32'd1);
    rx = '0;
    for (int k = 0; k < 10; k++) begin
      b0 = tx_s;
      #(SLOW_CPB * 2 - 2);
      b1 = tx_s;
      if (k == 9) check("t5_done_last", 32'(done_s), 32'd1);
      #2;
      check("t5_bit_head", 32'(b0), 32'(exp_s[4'(k)]));
      check("t5_bit_tail", 32'(b1), 32'(exp_s[4'(k)]));
      rx[4'(k)] = b1;
    end
    check("t5_loopback", 32'(rx[8:1]), 32'h0D);
    check("t5_busy_after", 32'(busy_s), 32'd0);
    check("t5_empty_end", 32'(empty_s), 32'd1);
    check("t5_full_end", 32'(full_s), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
